// File: rtl/petri_token_game_driver_if.sv
// Bus between the dining-philosophers token-game driver and its consumer.
// en is a level enable, not a valid/ready pair: the driver fires only on edges where en=1,
// and each t strobe is a single-cycle pulse with no back-pressure, so the consumer must act on it that cycle.
interface petri_token_game_driver_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [4:0]       hungry;
    logic             t0, t1, t2, t3, t4, t5, t6, t7, t8, t9;
    logic [9:0]       marking;
    logic [CNT_W-1:0] fire_cnt;
    logic [3:0]       rr_ptr;

    modport master (
        input  en, hungry,
        output t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, marking, fire_cnt, rr_ptr
    );

    modport slave (
        output en, hungry,
        input  t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, marking, fire_cnt, rr_ptr
    );
endinterface

// File: rtl/petri_token_game_driver.sv
// Token-game driver for the 5-dining-philosophers Petri net: round-robin firing with eat timers.
// Optional macro CONCURRENT_FIRE_EN switches to maximal-step firing (all releases plus greedy takes).
module petri_token_game_driver #(
    parameter int EAT_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input logic                       clk,
    input logic                       reset,
    petri_token_game_driver_if.master bus
);
    localparam logic [7:0] EAT_LOAD = 8'(EAT_CYCLES - 1);

    logic [9:0]       marking_q, marking_d;
    logic [9:0]       t_q, t_d;
    logic [4:0][7:0]  timer_q, timer_d;
    logic [3:0]       rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [9:0]       fire_en, fire_sel;
    logic [3:0]       first_k, k;
    logic [4:0]       sum;
    logic             found;
    logic [CNT_W-1:0] n_fired;
`ifdef CONCURRENT_FIRE_EN
    logic [3:0]       lt, rt;
`endif

    // State register: marking, timers, arbiter pointer, counter and strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            marking_q <= 10'b01_0101_0101;
            t_q       <= '0;
            timer_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            marking_q <= marking_d;
            t_q       <= t_d;
            timer_q   <= timer_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: enable rules, arbitration, then marking/timer/pointer updates.
    always_comb begin
        fire_en = '0;
        for (int i = 0; i < 5; i++) begin
            fire_en[2*i]   = marking_q[2*i] & bus.hungry[i]
                           & ~marking_q[2*((i+4)%5)+1] & ~marking_q[2*((i+1)%5)+1];
            fire_en[2*i+1] = marking_q[2*i+1] & (timer_q[i] == 8'd0);
        end

        fire_sel = '0;
        first_k  = rr_q;
        found    = 1'b0;
        sum      = '0;
        k        = '0;
`ifdef CONCURRENT_FIRE_EN
        lt       = '0;
        rt       = '0;
`endif
        for (int j = 0; j < 10; j++) begin
            sum = {1'b0, rr_q} + 5'(j);
            k   = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
`ifdef CONCURRENT_FIRE_EN
            // lt/rt are the take transitions of the left/right neighbour of take k.
            lt = (k == 4'd0) ? 4'd8 : k - 4'd2;
            rt = (k == 4'd8) ? 4'd0 : k + 4'd2;
            if (k[0])
                fire_sel[k] = fire_en[k];
            else
                fire_sel[k] = fire_en[k] & ~fire_sel[lt] & ~fire_sel[rt];
            if (fire_sel[k] && !found) begin
                found   = 1'b1;
                first_k = k;
            end
`else
            if (fire_en[k] && !found) begin
                found       = 1'b1;
                fire_sel[k] = 1'b1;
                first_k     = k;
            end
`endif
        end

`ifdef CONCURRENT_FIRE_EN
        n_fired = '0;
        for (int b = 0; b < 10; b++) n_fired = n_fired + CNT_W'(fire_sel[b]);
`else
        n_fired = CNT_W'(1);
`endif

        marking_d = marking_q;
        timer_d   = timer_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        t_d       = '0;
        if (bus.en) begin
            for (int i = 0; i < 5; i++) begin
                timer_d[i] = (timer_q[i] != 8'd0) ? timer_q[i] - 8'd1 : 8'd0;
                if (fire_sel[2*i]) begin
                    marking_d[2*i]   = 1'b0;
                    marking_d[2*i+1] = 1'b1;
                    timer_d[i]       = EAT_LOAD;
                end
                if (fire_sel[2*i+1]) begin
                    marking_d[2*i+1] = 1'b0;
                    marking_d[2*i]   = 1'b1;
                end
            end
            t_d = fire_sel;
            if (found) begin
                rr_d  = (first_k == 4'd9) ? 4'd0 : first_k + 4'd1;
                cnt_d = cnt_q + n_fired;
            end
        end
    end

    // Outputs straight from the registers.
    always_comb begin
        {bus.t9, bus.t8, bus.t7, bus.t6, bus.t5,
         bus.t4, bus.t3, bus.t2, bus.t1, bus.t0} = t_q;
        bus.marking  = marking_q;
        bus.fire_cnt = cnt_q;
        bus.rr_ptr   = rr_q;
    end

    // Net invariants: each philosopher in exactly one place, no two neighbours eating.
    logic inv_ok;
    always_comb begin
        inv_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(marking_q[2*i] ^ marking_q[2*i+1])) inv_ok = 1'b0;
            if (marking_q[2*i+1] && marking_q[2*((i+1)%5)+1]) inv_ok = 1'b0;
        end
`ifndef CONCURRENT_FIRE_EN
        if (!$onehot0(t_q)) inv_ok = 1'b0;
`endif
    end

    a_invariants: assert property (@(posedge clk) disable iff (!reset) inv_ok);

endmodule

// File: tb/tb_petri_token_game_driver.sv
// Randomized and directed bench for petri_token_game_driver against an array-based model of the net.
module tb_petri_token_game_driver;
    localparam int EAT = 4;
    localparam int CW  = 4;
    localparam int W   = 28;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    petri_token_game_driver_if #(.CNT_W(CW)) bus ();

    petri_token_game_driver #(.EAT_CYCLES(EAT), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    wire [9:0] t_vec = {bus.t9, bus.t8, bus.t7, bus.t6, bus.t5,
                        bus.t4, bus.t3, bus.t2, bus.t1, bus.t0};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who is eating, remaining eat time, arbiter pointer, counter.
    bit         m_eat[5];
    int         m_tmr[5];
    int         m_rr;
    int         m_cnt;
    int         m_total;
    logic [9:0] m_t;

    function automatic void m_reset();
        for (int i = 0; i < 5; i++) begin
            m_eat[i] = 0;
            m_tmr[i] = 0;
        end
        m_rr = 0; m_cnt = 0; m_t = '0;
    endfunction

    function automatic logic [9:0] m_marking();
        logic [9:0] m;
        for (int i = 0; i < 5; i++) begin
            m[2*i]   = !m_eat[i];
            m[2*i+1] = m_eat[i];
        end
        return m;
    endfunction

    function automatic bit m_enabled(input int k, input logic [4:0] h);
        int p = k / 2;
        if (k % 2 == 0)
            return !m_eat[p] && h[p] && !m_eat[(p+4)%5] && !m_eat[(p+1)%5];
        return m_eat[p] && m_tmr[p] == 0;
    endfunction

    function automatic void m_step(input bit en, input logic [4:0] h);
        logic [9:0] f = '0;
        int first = -1;
        m_t = '0;
        if (!en) return;
`ifdef CONCURRENT_FIRE_EN
        for (int k = 1; k < 10; k += 2) f[k] = m_enabled(k, h);
        for (int j = 0; j < 10; j++) begin
            int k = (m_rr + j) % 10;
            if (k % 2 == 0 && m_enabled(k, h) && !f[2*((k/2+4)%5)] && !f[2*((k/2+1)%5)])
                f[k] = 1'b1;
            if (f[k] && first < 0) first = k;
        end
`else
        for (int j = 0; j < 10; j++) begin
            int k = (m_rr + j) % 10;
            if (first < 0 && m_enabled(k, h)) begin
                f[k]  = 1'b1;
                first = k;
            end
        end
`endif
        for (int i = 0; i < 5; i++) begin
            if (m_tmr[i] > 0) m_tmr[i]--;
            if (f[2*i]) begin
                m_eat[i] = 1;
                m_tmr[i] = EAT - 1;
            end
            if (f[2*i+1]) m_eat[i] = 0;
        end
        if (first >= 0) begin
            m_rr     = (first + 1) % 10;
            m_cnt    = (m_cnt + $countones(f)) % (1 << CW);
            m_total += $countones(f);
        end
        m_t = f;
    endfunction

    // Scoreboard
    logic [W-1:0] exp_q[$];

    task automatic sb_check();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'(exp_q.size()), 1);
            return;
        end
        e = exp_q.pop_front();
        check_eq("t",        t_vec,        e[27:18]);
        check_eq("marking",  bus.marking,  e[17:8]);
        check_eq("rr_ptr",   bus.rr_ptr,   e[7:4]);
        check_eq("fire_cnt", bus.fire_cnt, e[3:0]);
    endtask

    // Drivers: called at a falling edge, drive, let one rising edge pass, check, return at a falling edge.
    task automatic step(input bit en, input logic [4:0] h);
        bus.en     = en;
        bus.hungry = h;
        m_step(en, h);
        exp_q.push_back({m_t, m_marking(), 4'(m_rr), CW'(m_cnt)});
        @(posedge clk);
        #1;
        sb_check();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [4:0] h);
        reset      = 1'b0;
        bus.en     = 1'b1;
        bus.hungry = h;
        m_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_marking", bus.marking, 10'h155);
        check_eq("rst_t",       t_vec,       0);
        check_eq("rst_cnt",     bus.fire_cnt, 0);
        check_eq("rst_rr",      bus.rr_ptr,  0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset      = 1'b0;
        bus.en     = 1'b0;
        bus.hungry = '0;
        @(negedge clk);

        // Reset and round-robin sequence with everyone hungry.
        do_reset(5'h1F);
`ifdef CONCURRENT_FIRE_EN
        step(1, 5'h1F);
        check_eq("conc_t0t4", t_vec, 10'h011);
        check_eq("conc_cnt",  bus.fire_cnt, 2);
`else
        step(1, 5'h1F);
        check_eq("first_t0", t_vec, 10'h001);
        step(1, 5'h1F);
        check_eq("rr_t4", t_vec, 10'h010);
        step(1, 5'h1F);
        check_eq("t6_t8_blocked", t_vec, 10'h000);
        step(1, 5'h1F);
        step(1, 5'h1F);
        check_eq("t1_after_4", t_vec, 10'h002);
`endif
        repeat (15) step(1, 5'h1F);

        // Blocking: philosopher 1 eats, then 0 and 2 become hungry.
        do_reset(5'h02);
        step(1, 5'h02);
        guard = 0;
        while (!m_t[3] && guard < 10) begin
            step(1, 5'b00101);
            guard++;
        end
        check_eq("block_t3_seen", 32'(m_t[3]), 1);
`ifndef CONCURRENT_FIRE_EN
        step(1, 5'b00101);
        check_eq("block_t4", t_vec, 10'h010);
`endif

        // Enable freeze mid-eat.
        do_reset(5'h01);
        step(1, 5'h01);
        step(1, 5'h00);
        repeat (5) step(0, 5'h1F);
        step(1, 5'h00);
        step(1, 5'h00);
        step(1, 5'h00);
        check_eq("en_release", t_vec, 10'h002);

        // Asynchronous reset while a strobe is high.
        do_reset(5'h1F);
        step(1, 5'h1F);
        check_eq("midrst_pre_t", 32'(|t_vec), 1);
        reset = 1'b0;
        #1;
        check_eq("midrst_t",       t_vec,        0);
        check_eq("midrst_marking", bus.marking,  10'h155);
        check_eq("midrst_cnt",     bus.fire_cnt, 0);
        @(negedge clk);

        // Counter wrap after 17 firings.
        do_reset(5'h1F);
        m_total = 0;
        guard   = 0;
        while (m_total < 17 && guard < 200) begin
            step(1, 5'h1F);
            guard++;
        end
        check_eq("wrap_budget", 32'(m_total >= 17), 1);
        check_eq("wrap_cnt", bus.fire_cnt, 32'(m_total % 16));

        // Random traffic.
        do_reset(5'($urandom_range(0, 31)));
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) != 0, 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
